// File: rtl/div_seq_32bit.sv
// Iterative restoring divider, one quotient bit per cycle, for DIV/DIVU.
// Optional DIV_EARLY_EXIT_EN: skip iteration when |dividend| < |divisor|.
module div_seq_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             sgn_q, sgn_d;
  logic             na_q, na_d;
  logic             nb_q, nb_d;
  logic             early_q, early_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   pw;
  logic [WIDTH-1:0] sub;
  logic             ge;
  logic             early;
  logic [WIDTH-1:0] fq, fr;

  always_comb begin
    mag_a = dividend;
    mag_b = divisor;
    if (is_signed && dividend[WIDTH-1]) mag_a = -dividend;
    if (is_signed && divisor[WIDTH-1])  mag_b = -divisor;
`ifdef DIV_EARLY_EXIT_EN
    early = (divisor != '0) && (mag_a < mag_b);
`else
    early = 1'b0;
`endif
    // pw < 2*b, so the difference always fits in WIDTH bits when kept
    pw  = {p_q, a_q[WIDTH-1]};
    ge  = pw >= {1'b0, b_q};
    sub = pw[WIDTH-1:0] - b_q;
    fq  = (sgn_q && (na_q ^ nb_q)) ? -a_q : a_q;
    fr  = (sgn_q && na_q) ? -p_q : p_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    sgn_d   = sgn_q;
    na_d    = na_q;
    nb_d    = nb_q;
    early_d = early_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = mag_a;
          b_d     = mag_b;
          p_d     = '0;
          cnt_d   = CW'(WIDTH);
          dvd_d   = dividend;
          sgn_d   = is_signed;
          na_d    = is_signed & dividend[WIDTH-1];
          nb_d    = is_signed & divisor[WIDTH-1];
          early_d = early;
          dz_d    = 1'b0;
          state_d = (divisor == '0 || early) ? FIXUP : ITER;
        end
      end
      ITER: begin
        p_d   = ge ? sub : pw[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (b_q == '0) begin
          quo_d = '1;
          rem_d = dvd_q;
          dz_d  = 1'b1;
        end else if (early_q) begin
          quo_d = '0;
          rem_d = dvd_q;
        end else begin
          quo_d = fq;
          rem_d = fr;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      dvd_q   <= '0;
      sgn_q   <= 1'b0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      early_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      sgn_q   <= sgn_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      early_q <= early_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = (state_q == ITER) || (state_q == FIXUP);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_seq_32bit.sv
// Directed bench for div_seq_32bit: results, latency, handshake, reset.
module tb_div_seq_32bit;

  localparam int W = 32;
`ifdef DIV_EARLY_EXIT_EN
  localparam int EE_LAT = 2;
`else
  localparam int EE_LAT = 34;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  div_seq_32bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ign_at: cycle at which a second start is pulsed while busy (0 = none)
  // sid: also pulse start in the done cycle and expect it ignored
  task automatic run(input string tag, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic sgn,
                     input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic edz, input int elat, input int ebusy,
                     input int ign_at, input logic sid);
    int k;
    int lat;
    int bn;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k   = 1;
    lat = 0;
    bn  = 0;
    while (k <= 60 && lat == 0) begin
      if (k == ign_at) begin
        start     = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = ~sgn;
      end else begin
        start = 1'b0;
      end
      if (busy) bn++;
      if (done) lat = k;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check({tag, "_lat"}, W'(lat), W'(elat));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, W'(div_by_zero), W'(edz));
    if (ebusy >= 0) check({tag, "_busy"}, W'(bn), W'(ebusy));
    if (sid) begin
      dividend = 32'd77;
      divisor  = 32'd5;
      start    = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_pulse"}, W'(done), '0);
    if (sid) check({tag, "_sid_busy"}, W'(busy), '0);
  endtask

  initial begin
    int dn;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_q", quotient, '0);
    check("rst_r", remainder, '0);
    check("rst_dz", W'(div_by_zero), '0);
    @(negedge clk);
    reset = 1'b0;

    run("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 33, 0, 1'b0);
    run("sn100_7", 32'hFFFFFF9C, 32'd7, 1'b1,
        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 33, 0, 1'b0);
    run("s100_n7", 32'd100, 32'hFFFFFFF9, 1'b1,
        32'hFFFFFFF2, 32'd2, 1'b0, 34, 33, 0, 1'b0);
    run("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1,
        32'h80000000, 32'd0, 1'b0, 34, 33, 0, 1'b0);
    run("u_big", 32'h80000000, 32'hFFFFFFFF, 1'b0,
        32'd0, 32'h80000000, 1'b0, EE_LAT, -1, 0, 1'b0);
    run("u_max1", 32'hFFFFFFFF, 32'd1, 1'b0,
        32'hFFFFFFFF, 32'd0, 1'b0, 34, 33, 0, 1'b0);
    run("dz", 32'd1234, 32'd0, 1'b0,
        32'hFFFFFFFF, 32'd1234, 1'b1, 2, -1, 0, 1'b0);
    run("u10_3", 32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0, 34, 33, 0, 1'b0);
    run("sdz", 32'hFFFFFF9C, 32'd0, 1'b1,
        32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 2, -1, 0, 1'b0);
    run("u5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, EE_LAT, -1, 0, 1'b0);
    run("hs", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 33, 5, 1'b1);

    @(negedge clk);
    dividend  = 32'd200;
    divisor   = 32'd7;
    is_signed = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", W'(busy), W'(1));
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", W'(busy), '0);
    check("mid_rst_done", W'(done), '0);
    check("mid_rst_q", quotient, '0);
    check("mid_rst_r", remainder, '0);
    check("mid_rst_dz", W'(div_by_zero), '0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("post_rst_nodone", W'(dn), '0);
    check("post_rst_busy", W'(busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
